// File: rtl/int_ctrl.sv
// Interrupt controller: per-source sync (INT_SYNC_EN), edge/level qualify, pending latch, enable mask, registered hwint.
// Latency irq->hwint 2 cycles (4 with INT_SYNC_EN); no backpressure, bus writes always accepted, reads combinational.
module int_ctrl #(
    parameter int NSRC = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irq,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [5:0]  hwint
);

    localparam logic [5:0] VMASK = 6'((7'd1 << NSRC) - 7'd1);

    logic [5:0] src;
    logic [5:0] en;
    logic [5:0] mode;
    logic [5:0] pend;
    logic [5:0] prev;
    logic [5:0] pend_next;
    logic [5:0] mode_chg;
    logic [5:0] w1c;
    logic [5:0] rise;
    logic [5:0] act;
    logic [2:0] idx;
    logic       unused_din;

    assign unused_din = ^din[31:6];

`ifdef INT_SYNC_EN
    logic [5:0] sync1;
    logic [5:0] sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 6'd0;
            sync2 <= 6'd0;
        end else begin
            sync1 <= irq & VMASK;
            sync2 <= sync1;
        end
    end

    assign src = sync2;
`else
    assign src = irq & VMASK;
`endif

    assign mode_chg = (we && addr == 2'd1) ? ((din[5:0] & VMASK) ^ mode) : 6'd0;
    assign w1c      = (we && addr == 2'd2) ? (din[5:0] & mode) : 6'd0;
    assign rise     = src & ~prev;

    // A new edge overrides a same-cycle W1C; a mode change clears the bit outright.
    assign pend_next = ~mode_chg & ((mode & ((pend & ~w1c) | rise)) | (~mode & src));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en    <= 6'd0;
            mode  <= 6'd0;
            pend  <= 6'd0;
            prev  <= 6'd0;
            hwint <= 6'd0;
        end else begin
            prev  <= src;
            pend  <= pend_next;
            hwint <= pend & en;
            if (we && addr == 2'd0) en <= din[5:0] & VMASK;
            if (we && addr == 2'd1) mode <= din[5:0] & VMASK;
        end
    end

    assign act = pend & en;

    always_comb begin
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (act[i]) idx = 3'(i);
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd0: dout[5:0] = en;
            2'd1: dout[5:0] = mode;
            2'd2: dout[5:0] = pend;
            2'd3: dout[3:0] = {|act, idx};
            default: dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl; inputs change on falling edges, outputs sampled in the low phase.
module tb_int_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [5:0]  hwint;

    int tests_run;
    int tests_failed;

    int_ctrl #(.NSRC(6)) dut (
        .clk   (clk),
        .reset (reset),
        .irq   (irq),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .hwint (hwint)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        din = d;
        @(negedge clk);
        we = 1'b0;
        din = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        if (hwint !== 6'd0) begin
            $display("FAIL reset_hwint got %h want 00", hwint); tests_failed++;
        end
        tests_run++;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            if (d !== 32'd0) begin
                $display("FAIL reset_reg%0d got %h want 0", a, d); tests_failed++;
            end
            tests_run++;
        end
    endtask

    task automatic test_reg_width();
        logic [31:0] d;
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, d);
        if (d !== 32'h3F) begin
            $display("FAIL en_width got %h want 3f", d); tests_failed++;
        end
        tests_run++;
        wr(2'd0, 32'd0);
    endtask

    task automatic test_level();
        logic [31:0] d;
        wr(2'd0, 32'h04);
        irq = 6'h04;
        tick();
        rd(2'd3, d);
        if (hwint !== 6'h00 || d !== 32'hA) begin
            $display("FAIL level_k got hwint %h status %h want 00 a", hwint, d); tests_failed++;
        end
        tests_run++;
        tick();
        if (hwint !== 6'h04) begin
            $display("FAIL level_k1 got %h want 04", hwint); tests_failed++;
        end
        tests_run++;
        tick();
        tick();
        irq = 6'h00;
        tick();
        rd(2'd2, d);
        if (hwint !== 6'h04 || d !== 32'h0) begin
            $display("FAIL level_k4 got hwint %h pend %h want 04 0", hwint, d); tests_failed++;
        end
        tests_run++;
        tick();
        if (hwint !== 6'h00) begin
            $display("FAIL level_k5 got %h want 00", hwint); tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_edge_w1c();
        logic [31:0] d;
        wr(2'd1, 32'h08);
        wr(2'd0, 32'h08);
        irq = 6'h08;
        tick();
        irq = 6'h00;
        tick();
        if (hwint !== 6'h08) begin
            $display("FAIL edge_latch got %h want 08", hwint); tests_failed++;
        end
        tests_run++;
        tick();
        tick();
        rd(2'd2, d);
        if (hwint !== 6'h08 || d !== 32'h08) begin
            $display("FAIL edge_hold got hwint %h pend %h want 08 08", hwint, d); tests_failed++;
        end
        tests_run++;
        wr(2'd2, 32'h08);
        rd(2'd2, d);
        if (hwint !== 6'h08 || d !== 32'h0) begin
            $display("FAIL w1c_edge got hwint %h pend %h want 08 0", hwint, d); tests_failed++;
        end
        tests_run++;
        tick();
        if (hwint !== 6'h00) begin
            $display("FAIL w1c_drop got %h want 00", hwint); tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_collision();
        logic [31:0] d;
        wr(2'd1, 32'h09);
        wr(2'd0, 32'h09);
        irq = 6'h01;
        we = 1'b1;
        addr = 2'd2;
        din = 32'h01;
        tick();
        we = 1'b0;
        din = 32'd0;
        rd(2'd2, d);
        if (d !== 32'h01) begin
            $display("FAIL collision got pend %h want 01", d); tests_failed++;
        end
        tests_run++;
        // irq[0] still high: no new edge, so a plain W1C must clear it
        wr(2'd2, 32'h01);
        tick();
        rd(2'd2, d);
        if (d !== 32'h00) begin
            $display("FAIL held_edge got pend %h want 00", d); tests_failed++;
        end
        tests_run++;
        irq = 6'h00;
        tick();
    endtask

    task automatic test_priority();
        logic [31:0] d;
        wr(2'd1, 32'h00);
        irq = 6'h12;
        wr(2'd0, 32'h12);
        tick();
        rd(2'd3, d);
        if (d !== 32'h9 || hwint !== 6'h12) begin
            $display("FAIL prio_both got status %h hwint %h want 9 12", d, hwint); tests_failed++;
        end
        tests_run++;
        wr(2'd0, 32'h10);
        rd(2'd3, d);
        if (d !== 32'hC) begin
            $display("FAIL prio_mask got status %h want c", d); tests_failed++;
        end
        tests_run++;
        tick();
        rd(2'd2, d);
        if (hwint !== 6'h10 || d !== 32'h12) begin
            $display("FAIL mask_keep got hwint %h pend %h want 10 12", hwint, d); tests_failed++;
        end
        tests_run++;
        wr(2'd0, 32'h12);
        tick();
        if (hwint !== 6'h12) begin
            $display("FAIL reenable got %h want 12", hwint); tests_failed++;
        end
        tests_run++;
        irq = 6'h00;
        wr(2'd0, 32'h00);
        tick();
        tick();
    endtask

    task automatic test_sync_latency();
        int lat;
`ifdef INT_SYNC_EN
        lat = 4;
`else
        lat = 2;
`endif
        wr(2'd0, 32'h20);
        tick();
        irq = 6'h20;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (hwint[5] !== (j >= lat - 1)) begin
                $display("FAIL sync_lat edge k+%0d got %b want %b", j, hwint[5], (j >= lat - 1));
                tests_failed++;
            end
            tests_run++;
        end
        irq = 6'h00;
        wr(2'd0, 32'h00);
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int bad;
        wr(2'd0, 32'h3F);
        irq = 6'h3F;
        for (int j = 0; j < 6; j++) tick();
        if (hwint !== 6'h3F) begin
            $display("FAIL pre_reset got %h want 3f", hwint); tests_failed++;
        end
        tests_run++;
        #2 reset = 1'b0;
        #1;
        if (hwint !== 6'h00 || dout !== 32'h0) begin
            $display("FAIL mid_reset got hwint %h dout %h want 00 0", hwint, dout); tests_failed++;
        end
        tests_run++;
        bad = 0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            if (d !== 32'h0) bad++;
        end
        if (bad != 0) begin
            $display("FAIL mid_reset_regs got %0d nonzero want 0", bad); tests_failed++;
        end
        tests_run++;
        tick();
        reset = 1'b1;
        tick();
        wr(2'd1, 32'h3F);
        wr(2'd0, 32'h3F);
        for (int j = 0; j < 6; j++) tick();
        rd(2'd2, d);
        if (d !== 32'h0 || hwint !== 6'h00) begin
            $display("FAIL held_after_reset got pend %h hwint %h want 0 00", d, hwint); tests_failed++;
        end
        tests_run++;
        irq = 6'h3D;
        tick();
        irq = 6'h3F;
        tick();
        rd(2'd2, d);
        if (d !== 32'h02) begin
            $display("FAIL new_edge got pend %h want 02", d); tests_failed++;
        end
        tests_run++;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        irq = 6'h00;
        we = 1'b0;
        addr = 2'd0;
        din = 32'd0;
        tick();
        test_reset();
        tick();
        reset = 1'b1;
        tick();
        test_reg_width();
        test_level();
        test_edge_w1c();
        test_collision();
        test_priority();
        test_sync_latency();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
